rtc_bus_ctrl: RTL
=================

Name: rtc_bus_ctrl

Overview:
Sequences a single multiplexed address/data transaction on the external RTC parallel bus: an address phase followed by a write-data or read-data phase.
- Commanded by the level controls escribe/lee and the dir/dato bytes produced by the PicoBlaze output-port register block.
- Emits a one-cycle fin pulse, which feeds that register block's rst input so the register block clears its command flags.
- Read data is captured into dato_leido for the PicoBlaze input port.

Parameters:
T_PULSE, 8, cycles that cs_n and wr_n/rd_n are held low in each phase; legal range 1..255.
T_GAP, 4, cycles that cs_n, rd_n and wr_n are high between phases and after the data phase; legal range 1..255.

Ports:
clk  in  1  system clock; all flops update on its rising edge.
reset  in  1  synchronous, active-high reset.
escribe  in  1  write command (level).
lee  in  1  read command (level).
dir  in  8  RTC register address.
dato  in  8  write data.
ad_in  in  8  bus value sampled from the AD pins.
ad_out  out  8  value driven onto the AD pins.
ad_oe  out  1  1 = drive ad_out onto the pins.
cs_n  out  1  chip select, active low.
rd_n  out  1  read strobe, active low.
wr_n  out  1  write strobe, active low.
ad_n  out  1  0 = address cycle, 1 = data cycle.
dato_leido  out  8  last byte read from the RTC.
busy  out  1  high in every state except IDLE.
fin  out  1  one-cycle completion pulse.

Behaviour:
Reset:
- Reset wins over every other input, including in the middle of a transaction.
- The next state is IDLE; the counter is cleared.
- Output values: cs_n=1, rd_n=1, wr_n=1, ad_n=1, ad_oe=0, ad_out=0x00, dato_leido=0x00, busy=0, fin=0.
- A transaction cut off by reset does not produce fin and does not update dato_leido.

Output registration:
- All outputs are registered and take the value that belongs to the state being entered on that same edge.

States and transitions:
- IDLE: if escribe=1 or lee=1, latch dir, dato and op (write when escribe=1, which gives write priority when both are high), then go to ADDR_PULSE. Otherwise stay in IDLE.
- ADDR_PULSE: T_PULSE cycles. cs_n=0, wr_n=0, ad_n=0, ad_oe=1, ad_out=latched dir. Then go to ADDR_GAP.
- ADDR_GAP: T_GAP cycles. cs_n=1, wr_n=1, ad_n=0, ad_oe=1, ad_out=dir (address hold). Then go to DATA_PULSE.
- DATA_PULSE, write: T_PULSE cycles. cs_n=0, wr_n=0, ad_n=1, ad_oe=1, ad_out=latched dato.
- DATA_PULSE, read: T_PULSE cycles. cs_n=0, rd_n=0, ad_n=1, ad_oe=0. On the edge that leaves this state, dato_leido <= ad_in.
- DATA_GAP: T_GAP cycles. All strobes high, ad_n=1. On a write, ad_oe=1 and ad_out=dato (data hold). On a read, ad_oe=0. Then go to DONE.
- DONE: 1 cycle, fin=1. Then go to IDLE.

Counter rules:
- An 8-bit down-counter is loaded with the phase length minus 1 on entry to each timed state.
- The state advances on the cycle where the counter = 0.

Timing:
- busy is high for exactly 2*(T_PULSE+T_GAP)+1 cycles, starting the cycle after the command is accepted.
- fin is high in the last of those cycles.
- rd_n and wr_n are never both low. ad_oe is never 1 while rd_n=0.

Command handling:
- escribe, lee, dir and dato are ignored while busy=1. Their changes never alter a transaction in flight.
- A command still high when the FSM returns to IDLE starts a new transaction. The upstream register block clears its flags on fin, so this does not happen in normal operation.

Test Plan:
1. T_PULSE=3, T_GAP=2; escribe=1, dir=0x21, dato=0x45 -> ad_n=0 with ad_out=0x21 and wr_n=0 for 3 cycles; 2 gap cycles; ad_out=0x45 with wr_n=0 for 3 cycles; 2 gap cycles; fin for 1 cycle; busy high 11 cycles; rd_n stays 1.
2. Read, dir=0x33, ad_in=0x59 during DATA_PULSE -> wr_n low only in the address phase; rd_n low 3 cycles with ad_oe=0; dato_leido=0x59 after DONE; fin pulses once.
3. escribe=1 and lee=1 in the same cycle -> write sequence only; rd_n never asserted.
4. During a write, change dir to 0xFF and dato to 0x00 and raise lee -> bus still shows 0x21 and 0x45; exactly one fin.
5. Assert reset in the 2nd cycle of DATA_PULSE on a read -> next cycle all reset values apply (cs_n=1, busy=0); fin is never pulsed; dato_leido stays at its prior value 0x00.
6. escribe held high continuously -> a second 11-cycle transaction starts the cycle after fin (IDLE lasts 1 cycle); T_PULSE=1 and T_GAP=1 edge case gives busy high 5 cycles.

Source files
------------

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl
//   Runs one multiplexed address/data transaction on the external RTC
//   parallel bus: an address phase, then a write-data or read-data phase,
//   then a one-cycle fin pulse that clears the PicoBlaze command flags.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high reset
//   escribe    : write command (level, sampled only in IDLE)
//   lee        : read command (level, sampled only in IDLE)
//   dir        : RTC register address
//   dato       : write data
//   ad_in      : value sampled from the AD pins
//   ad_out     : value driven onto the AD pins
//   ad_oe      : 1 = drive ad_out onto the pins
//   cs_n       : chip select, active low
//   rd_n       : read strobe, active low
//   wr_n       : write strobe, active low
//   ad_n       : 0 = address cycle, 1 = data cycle
//   dato_leido : last byte read from the RTC
//   busy       : high in every state except IDLE
//   fin        : one-cycle completion pulse
module rtc_bus_ctrl #(
  parameter int unsigned T_PULSE = 8,
  parameter int unsigned T_GAP   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       escribe,
  input  logic       lee,
  input  logic [7:0] dir,
  input  logic [7:0] dato,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_n,
  output logic [7:0] dato_leido,
  output logic       busy,
  output logic       fin
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] ADDR_PULSE = 3'd1;
  localparam logic [2:0] ADDR_GAP   = 3'd2;
  localparam logic [2:0] DATA_PULSE = 3'd3;
  localparam logic [2:0] DATA_GAP   = 3'd4;
  localparam logic [2:0] DONE       = 3'd5;

  // Down-counter reload values: a phase of N cycles ends when the count hits 0.
  localparam logic [7:0] PULSE_LOAD = 8'(T_PULSE - 32'd1);
  localparam logic [7:0] GAP_LOAD   = 8'(T_GAP - 32'd1);

  logic [2:0] state_r, state_s;
  logic [7:0] cnt_r, cnt_s;
  logic [7:0] dir_r, dir_s;
  logic [7:0] dato_r, dato_s;
  logic       op_wr_r, op_wr_s;
  logic       capture_s;

  logic       cs_n_s, rd_n_s, wr_n_s, ad_n_s, ad_oe_s, busy_s, fin_s;
  logic [7:0] ad_out_s;

  // Next-state, phase counter and command latching.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    dir_s     = dir_r;
    dato_s    = dato_r;
    op_wr_s   = op_wr_r;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (escribe || lee) begin
          dir_s   = dir;
          dato_s  = dato;
          op_wr_s = escribe;     // write wins when both commands are high
          state_s = ADDR_PULSE;
          cnt_s   = PULSE_LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      ADDR_PULSE: begin
        if (cnt_r == 8'd0) begin
          state_s = ADDR_GAP;
          cnt_s   = GAP_LOAD;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      ADDR_GAP: begin
        if (cnt_r == 8'd0) begin
          state_s = DATA_PULSE;
          cnt_s   = PULSE_LOAD;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      DATA_PULSE: begin
        if (cnt_r == 8'd0) begin
          state_s   = DATA_GAP;
          cnt_s     = GAP_LOAD;
          capture_s = ~op_wr_r;  // read data is taken while rd_n is still low
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      DATA_GAP: begin
        if (cnt_r == 8'd0) begin
          state_s = DONE;
          cnt_s   = 8'd0;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      DONE: begin
        state_s = IDLE;
        cnt_s   = 8'd0;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 8'd0;
      end
    endcase
  end

  // Output values belonging to the state being entered, so they can be registered.
  always_comb begin
    cs_n_s   = 1'b1;
    rd_n_s   = 1'b1;
    wr_n_s   = 1'b1;
    ad_n_s   = 1'b1;
    ad_oe_s  = 1'b0;
    ad_out_s = 8'h00;
    busy_s   = 1'b1;
    fin_s    = 1'b0;
    case (state_s)
      IDLE: begin
        busy_s = 1'b0;
      end
      ADDR_PULSE: begin
        cs_n_s   = 1'b0;
        wr_n_s   = 1'b0;
        ad_n_s   = 1'b0;
        ad_oe_s  = 1'b1;
        ad_out_s = dir_s;
      end
      ADDR_GAP: begin
        ad_n_s   = 1'b0;
        ad_oe_s  = 1'b1;
        ad_out_s = dir_s;
      end
      DATA_PULSE: begin
        cs_n_s = 1'b0;
        if (op_wr_s) begin
          wr_n_s   = 1'b0;
          ad_oe_s  = 1'b1;
          ad_out_s = dato_s;
        end else begin
          rd_n_s  = 1'b0;        // bus released so the RTC can drive AD
          ad_oe_s = 1'b0;
        end
      end
      DATA_GAP: begin
        if (op_wr_s) begin
          ad_oe_s  = 1'b1;
          ad_out_s = dato_s;
        end else begin
          ad_oe_s = 1'b0;
        end
      end
      DONE: begin
        fin_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // State, latched command and registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      dir_r      <= 8'h00;
      dato_r     <= 8'h00;
      op_wr_r    <= 1'b0;
      cs_n       <= 1'b1;
      rd_n       <= 1'b1;
      wr_n       <= 1'b1;
      ad_n       <= 1'b1;
      ad_oe      <= 1'b0;
      ad_out     <= 8'h00;
      dato_leido <= 8'h00;
      busy       <= 1'b0;
      fin        <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      dir_r   <= dir_s;
      dato_r  <= dato_s;
      op_wr_r <= op_wr_s;
      cs_n    <= cs_n_s;
      rd_n    <= rd_n_s;
      wr_n    <= wr_n_s;
      ad_n    <= ad_n_s;
      ad_oe   <= ad_oe_s;
      ad_out  <= ad_out_s;
      busy    <= busy_s;
      fin     <= fin_s;
      if (capture_s) begin
        dato_leido <= ad_in;
      end else begin
        dato_leido <= dato_leido;
      end
    end
  end

endmodule
